// File: rtl/uart_tx_packet_sink.sv
// 8N1 UART transmitter fed from a valid/ready/last byte stream through a small FIFO.
// Frames run back-to-back while bytes are queued; packet_done marks the end of a last-tagged byte.
module uart_tx_packet_sink #(
  parameter int CLOCKS_PER_BIT = 868,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        packet_valid,
  input  logic [7:0]  packet_data,
  input  logic        packet_last,
  output logic        packet_ready,
  output logic        uart_tx,
  output logic        busy,
  output logic        packet_done,
  output logic [15:0] packet_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int DW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLOCKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  logic [8:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_s;
  logic          pop_s;
  logic          empty_s;
  logic [8:0]    head_s;

  state_t        state_r;
  state_t        state_s;
  logic [DW-1:0] div_r;
  logic [DW-1:0] div_s;
  logic          div_wrap_s;
  logic [2:0]    bit_idx_r;
  logic [2:0]    bit_idx_s;
  logic [7:0]    shift_r;
  logic [7:0]    shift_s;
  logic          last_r;
  logic          last_s;
  logic          tx_r;
  logic          tx_s;
  logic          done_r;
  logic          done_s;
  logic [15:0]   pkt_cnt_r;

  // ready comes only from the registered occupancy, never from packet_valid
  assign packet_ready = (count_r != FULL_COUNT);
  assign empty_s      = (count_r == {(AW + 1){1'b0}});
  assign push_s       = packet_valid && packet_ready;
  assign head_s       = mem_r[rd_ptr_r];
  assign div_wrap_s   = (div_r == DIV_LAST);

  assign uart_tx      = tx_r;
  assign packet_done  = done_r;
  assign packet_count = pkt_cnt_r;
  assign busy         = !empty_s || (state_r != ST_IDLE);

  // FIFO storage write port
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {packet_last, packet_data};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Serialiser next-state, FIFO pop and next line level
  always_comb begin
    state_s   = state_r;
    div_s     = div_wrap_s ? {DW{1'b0}} : div_r + 1'b1;
    bit_idx_s = bit_idx_r;
    shift_s   = shift_r;
    last_s    = last_r;
    pop_s     = 1'b0;
    done_s    = 1'b0;
    tx_s      = 1'b1;
    case (state_r)
      ST_IDLE: begin
        div_s = {DW{1'b0}};
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_s = head_s[7:0];
          last_s  = head_s[8];
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        tx_s = 1'b0;
        if (div_wrap_s) begin
          bit_idx_s = 3'd0;
          state_s   = ST_DATA;
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        tx_s = shift_r[bit_idx_r];
        if (div_wrap_s && (bit_idx_r == 3'd7)) begin
          state_s = ST_STOP;
        end else if (div_wrap_s) begin
          bit_idx_s = bit_idx_r + 3'd1;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_STOP: begin
        tx_s = 1'b1;
        if (div_wrap_s) begin
          done_s = last_r;
          // chain straight into the next start bit when another byte is waiting
          if (!empty_s) begin
            pop_s   = 1'b1;
            shift_s = head_s[7:0];
            last_s  = head_s[8];
            state_s = ST_START;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        div_s   = {DW{1'b0}};
      end
    endcase
  end

  // Serialiser registers; tx_r follows the state one cycle later
  always_ff @(posedge clock) begin
    if (clear) begin
      state_r   <= ST_IDLE;
      div_r     <= {DW{1'b0}};
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
      last_r    <= 1'b0;
      tx_r      <= 1'b1;
      done_r    <= 1'b0;
      pkt_cnt_r <= 16'd0;
    end else begin
      state_r   <= state_s;
      div_r     <= div_s;
      bit_idx_r <= bit_idx_s;
      shift_r   <= shift_s;
      last_r    <= last_s;
      tx_r      <= tx_s;
      done_r    <= done_s;
      if (done_s) begin
        pkt_cnt_r <= pkt_cnt_r + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_packet_sink.sv
// Scoreboard bench for uart_tx_packet_sink (4 clocks per bit, 4-entry FIFO).
// The driver queues {last,data} on each handshake; a line decoder pops and compares every frame.
module tb_uart_tx_packet_sink;

  logic        clk = 1'b0;
  logic        clear;
  logic        packet_valid;
  logic [7:0]  packet_data;
  logic        packet_last;
  logic        packet_ready;
  logic        uart_tx;
  logic        busy;
  logic        packet_done;
  logic [15:0] packet_count;

  uart_tx_packet_sink #(.CLOCKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clock        (clk),
    .clear        (clear),
    .packet_valid (packet_valid),
    .packet_data  (packet_data),
    .packet_last  (packet_last),
    .packet_ready (packet_ready),
    .uart_tx      (uart_tx),
    .busy         (busy),
    .packet_done  (packet_done),
    .packet_count (packet_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [8:0]  exp_q[$];
  int          frm_start[$];
  int          frm_end[$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          chk_full_frames = 0;
  logic [15:0] exp_pkts = 16'd0;
  logic        dec_active = 1'b0;
  int          dec_k = 0;
  logic [7:0]  dec_byte = 8'd0;
  logic [8:0]  cur_exp = 9'd0;
  logic        saw_not_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line decoder: samples mid-bit, pops the scoreboard at the stop bit
  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      cyc++;
      if (packet_done) done_cnt++;
      if (clear) begin
        dec_active = 1'b0;
        exp_pkts   = 16'd0;
      end else if (!dec_active) begin
        if (uart_tx == 1'b0) begin
          dec_active = 1'b1;
          dec_k      = 0;
          frm_start.push_back(cyc);
        end
      end else begin
        dec_k++;
        if (dec_k >= 6 && dec_k <= 34 && ((dec_k - 6) % 4) == 0)
          dec_byte = {uart_tx, dec_byte[7:1]};
        if (dec_k == 37 && chk_full_frames > 0)
          check("ready_low_when_full", 32'(packet_ready), 32'd0);
        if (dec_k == 38) begin
          check("stop_bit", 32'(uart_tx), 32'd1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_frame: got 0x%02h expected no frame", dec_byte);
            cur_exp = 9'd0;
          end else begin
            cur_exp = exp_q.pop_front();
            check("line_byte", 32'(dec_byte), 32'(cur_exp[7:0]));
          end
        end
        if (dec_k == 39) begin
          if (cur_exp[8]) exp_pkts = exp_pkts + 16'd1;
          check("packet_done", 32'(packet_done), 32'(cur_exp[8]));
          check("packet_count", 32'(packet_count), 32'(exp_pkts));
          if (chk_full_frames > 0) begin
            check("ready_after_pop", 32'(packet_ready), 32'd1);
            chk_full_frames--;
          end
          frm_end.push_back(cyc);
          dec_active = 1'b0;
        end
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic push_byte(input logic [7:0] d, input logic l);
    int guard = 0;
    packet_valid = 1'b1;
    packet_data  = d;
    packet_last  = l;
    while (!packet_ready && guard < 2000) begin
      saw_not_ready = 1'b1;
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) begin
      check("push_timeout", 32'(guard), 32'd0);
    end else begin
      exp_q.push_back({l, d});
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    repeat (4) @(negedge clk);
    check("drain_timeout", 32'(guard >= 3000), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    clear = 1'b1;
    packet_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_ready", 32'(packet_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(packet_done), 32'd0);
    check("rst_count", 32'(packet_count), 32'd0);
    clear = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int base_s;
    int base_e;
    int base_d;
    int nlast;
    logic [7:0] hdr [6];
    logic [7:0] d;
    logic       l;

    clear        = 1'b1;
    packet_valid = 1'b0;
    packet_data  = 8'd0;
    packet_last  = 1'b0;
    fork
      monitor_loop();
    join_none

    do_reset();

    // 1: single byte 0x44, start bit two edges after the push
    base_d = done_cnt;
    push_byte(8'h44, 1'b1);
    packet_valid = 1'b0;
    check("lat_e1_idle", 32'(uart_tx), 32'd1);
    @(negedge clk);
    check("lat_e2_idle", 32'(uart_tx), 32'd1);
    @(negedge clk);
    check("lat_start", 32'(uart_tx), 32'd0);
    wait_idle();
    check("t1_done_pulses", 32'(done_cnt - base_d), 32'd1);
    check("t1_count", 32'(packet_count), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);

    // 2: header stream with valid held high, frames back-to-back
    hdr[0] = 8'h44; hdr[1] = 8'h00; hdr[2] = 8'h03;
    hdr[3] = 8'hAA; hdr[4] = 8'hBB; hdr[5] = 8'hCC;
    base_s = frm_start.size();
    base_e = frm_end.size();
    base_d = done_cnt;
    saw_not_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_byte(hdr[i], (i == 5) ? 1'b1 : 1'b0);
    packet_valid = 1'b0;
    wait_idle();
    check("t2_ready_dropped", 32'(saw_not_ready), 32'd1);
    check("t2_frames", 32'(frm_end.size() - base_e), 32'd6);
    if (frm_end.size() - base_e == 6 && frm_start.size() > base_s)
      check("t2_span_cycles", 32'(frm_end[base_e + 5] - frm_start[base_s] + 1), 32'd240);
    check("t2_done_pulses", 32'(done_cnt - base_d), 32'd1);
    check("t2_count", 32'(packet_count), 32'd2);

    // 3: fill the FIFO, keep valid high; ready must reopen for one cycle per pop
    base_d = done_cnt;
    saw_not_ready = 1'b0;
    chk_full_frames = 5;
    for (int i = 0; i < 10; i++) push_byte(8'h10 + 8'(i), (i == 9) ? 1'b1 : 1'b0);
    packet_valid = 1'b0;
    wait_idle();
    check("t3_ready_dropped", 32'(saw_not_ready), 32'd1);
    check("t3_full_frames_seen", 32'(chk_full_frames), 32'd0);
    check("t3_done_pulses", 32'(done_cnt - base_d), 32'd1);
    check("t3_count", 32'(packet_count), 32'd3);

    // 4: clear during data bit 3 with two bytes buffered
    do_reset();
    push_byte(8'h81, 1'b0);
    push_byte(8'h82, 1'b0);
    push_byte(8'h83, 1'b1);
    packet_valid = 1'b0;
    repeat (17) @(negedge clk);
    base_d = done_cnt;
    clear = 1'b1;
    @(negedge clk);
    check("t4_tx_high", 32'(uart_tx), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_ready", 32'(packet_ready), 32'd1);
    @(negedge clk);
    clear = 1'b0;
    exp_q.delete();
    base_s = frm_start.size();
    repeat (120) @(negedge clk);
    check("t4_no_new_frame", 32'(frm_start.size() - base_s), 32'd0);
    check("t4_no_done", 32'(done_cnt - base_d), 32'd0);
    check("t4_count", 32'(packet_count), 32'd0);
    check("t4_line_idle", 32'(uart_tx), 32'd1);

    // 5: packet_count wraps from 0xFFFF to 0
    force dut.pkt_cnt_r = 16'hFFFF;
    @(negedge clk);
    release dut.pkt_cnt_r;
    @(negedge clk);
    check("t5_preload", 32'(packet_count), 32'h0000FFFF);
    exp_pkts = 16'hFFFF;
    base_d = done_cnt;
    push_byte(8'h5A, 1'b1);
    packet_valid = 1'b0;
    wait_idle();
    check("t5_wrap_count", 32'(packet_count), 32'd0);
    check("t5_done_pulses", 32'(done_cnt - base_d), 32'd1);

    // 6: 200 random bytes with random gaps and last flags
    base_d = done_cnt;
    base_e = frm_end.size();
    nlast  = 0;
    for (int i = 0; i < 200; i++) begin
      d = 8'($urandom_range(0, 255));
      l = ($urandom_range(0, 3) == 0);
      if (l) nlast++;
      push_byte(d, l);
      packet_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    check("t6_frames", 32'(frm_end.size() - base_e), 32'd200);
    check("t6_done_pulses", 32'(done_cnt - base_d), 32'(nlast));
    check("t6_count", 32'(packet_count), 32'(nlast));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
